cmd_out_shaper: RTL and testbench

Transmit-side command output shaper: the counterpart of the input command filter. Converts a command request from core logic into an output line level held long enough, in filter steps, for a `FILTER_WIDTH` input filter at the far end to accept it, then enforces a guard gap before the next command. Sits between the command logic and the output pin register; one instance per command line.

---
 rtl/cmd_out_shaper.sv | 109 ++++++++++
 tb/tb_cmd_out_shaper.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cmd_out_shaper.sv
// Command output shaper: holds a request active for HOLD_STEPS strobes (+1 clock), then a GAP_STEPS guard gap.
// Optional macro CMD_OUT_PENDING_EN latches requests seen during the gap so they are served right after it.
module cmd_out_shaper #(
  parameter int   FILTER_WIDTH = 2,
  parameter int   HOLD_STEPS   = 2**FILTER_WIDTH,
  parameter int   GAP_STEPS    = 2,
  parameter logic OUT_DEFAULT  = 1'b1
) (
  input  logic i_clk,
  input  logic i_aclr,
  input  logic i_req,
  input  logic i_stb,
  output logic o_out,
  output logic o_busy
);

  localparam int MAX_STEPS = (HOLD_STEPS > GAP_STEPS) ? HOLD_STEPS : GAP_STEPS;
  localparam int CW        = $clog2(MAX_STEPS + 1);

  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_STEPS);
  localparam logic [CW-1:0] GAP_C  = CW'(GAP_STEPS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic          r_busy;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_gap_req;

`ifdef CMD_OUT_PENDING_EN
  logic r_pend;
  logic w_pend_nxt;
  // A request sampled on the gap's final edge is as good as one latched earlier.
  assign w_gap_req = r_pend | i_req;
`else
  assign w_gap_req = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
`ifdef CMD_OUT_PENDING_EN
    w_pend_nxt  = r_pend;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_req) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (r_cnt == HOLD_C && !i_req) begin
          w_state_nxt = (GAP_STEPS == 0) ? S_IDLE : S_GAP;
          w_cnt_nxt   = '0;
        end else if (i_stb && r_cnt != HOLD_C) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_C) begin
          w_state_nxt = w_gap_req ? S_ACTIVE : S_IDLE;
          w_cnt_nxt   = '0;
`ifdef CMD_OUT_PENDING_EN
          w_pend_nxt  = 1'b0;
`endif
        end else begin
`ifdef CMD_OUT_PENDING_EN
          w_pend_nxt = w_gap_req;
`endif
          if (i_stb) w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they track the FSM without any input-to-output path.
  always_ff @(posedge i_clk) begin
    if (i_aclr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_out   <= OUT_DEFAULT;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= (w_state_nxt == S_ACTIVE) ? ~OUT_DEFAULT : OUT_DEFAULT;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef CMD_OUT_PENDING_EN
  always_ff @(posedge i_clk) begin
    if (i_aclr) r_pend <= 1'b0;
    else        r_pend <= w_pend_nxt;
  end
`endif

  assign o_out  = r_out;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_cmd_out_shaper.sv
// Directed bench for cmd_out_shaper with HOLD_STEPS=4, GAP_STEPS=2, OUT_DEFAULT=1.
module tb_cmd_out_shaper;

  logic clk = 1'b0;
  logic aclr = 1'b0;
  logic req = 1'b0;
  logic stb = 1'b1;
  logic dut_out;
  logic dut_busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic req;
    logic stb;
    logic aclr;
    logic exp_out;
    logic exp_busy;
  } vec_t;

  vec_t vecs[$];

  cmd_out_shaper #(
    .FILTER_WIDTH(2),
    .HOLD_STEPS(4),
    .GAP_STEPS(2),
    .OUT_DEFAULT(1'b1)
  ) dut (
    .i_clk (clk),
    .i_aclr(aclr),
    .i_req (req),
    .i_stb (stb),
    .o_out (dut_out),
    .o_busy(dut_busy)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic s, input logic a,
                              input logic eo, input logic eb);
    vec_t v;
    v.req = r; v.stb = s; v.aclr = a; v.exp_out = eo; v.exp_busy = eb;
    vecs.push_back(v);
  endfunction

  // Drive inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input logic r, input logic s, input logic a,
                      input logic eo, input logic eb, input string name);
    req = r; stb = s; aclr = a;
    @(posedge clk);
    #1;
    tests++;
    if (dut_out !== eo || dut_busy !== eb) begin
      fails++;
      $display("FAIL %s: out=%b busy=%b, expected out=%b busy=%b", name, dut_out, dut_busy, eo, eb);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    req = 1'b0; stb = 1'b1; aclr = 1'b0;
    while (dut_busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (dut_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy=%b after %0d clocks, expected 0", name, dut_busy, n);
    end
  endtask

  initial begin
    // Reset, then idle with req low for 10 clocks.
    add(0, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 1, 0);
    // Single-clock request: 5 clocks active, 3 clocks gap, then idle.
    add(1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 1);
    add(0, 1, 0, 1, 0);
    add(0, 1, 0, 1, 0);
    // Request held 10 clocks: stretched past saturation, then the gap.
    for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 1);
    add(0, 1, 0, 1, 0);

    foreach (vecs[k]) step(vecs[k].req, vecs[k].stb, vecs[k].aclr,
                           vecs[k].exp_out, vecs[k].exp_busy, $sformatf("vec%0d", k));

    // Strobe stuck low: command held indefinitely, then four strobes release it.
    step(1, 0, 0, 0, 1, "stb0_entry");
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 1, $sformatf("stb0_hold%0d", i));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, $sformatf("stb0_pulse%0d", i));
    step(0, 0, 0, 1, 1, "stb0_release");
    drain("stb0_drain");

    // Short request arriving in the middle of the gap.
    step(1, 1, 0, 0, 1, "pend_entry");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, $sformatf("pend_act%0d", i));
    step(0, 1, 0, 1, 1, "pend_gap0");
    step(1, 1, 0, 1, 1, "pend_gap1_req");
    step(0, 1, 0, 1, 1, "pend_gap2");
`ifdef CMD_OUT_PENDING_EN
    step(0, 1, 0, 0, 1, "pend_served");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, $sformatf("pend_hold%0d", i));
    step(0, 1, 0, 1, 1, "pend_served_gap");
    drain("pend_drain");
`else
    step(0, 1, 0, 1, 0, "pend_dropped");
    step(0, 1, 0, 1, 0, "pend_idle");
`endif

    // Reset mid-command with req high, then a fresh full-length command.
    step(1, 1, 0, 0, 1, "clr_entry");
    step(0, 1, 0, 0, 1, "clr_cnt1");
    step(0, 1, 0, 0, 1, "clr_cnt2");
    step(1, 1, 1, 1, 0, "clr_reset");
    step(1, 1, 0, 0, 1, "clr_restart");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, $sformatf("clr_hold%0d", i));
    step(0, 1, 0, 1, 1, "clr_gap");
    drain("clr_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
